io_read_arbiter: RTL
====================

Name: io_read_arbiter

Overview:
Shares the single IO read channel between the two cores' IO load/store sub-units in the dual-core system. Each core's IO sub-unit issues a one-cycle read request with an address. The arbiter latches each request, grants the channel round-robin, and runs one AXI-lite-style read (AR handshake, then R) at a time. It returns data, valid and error to the owning core. A per-transaction timeout guarantees forward progress if the slave never responds.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 256, maximum cycles spent in DATA before a forced error response; 0 disables the timeout
TIMEOUT_DATA, 32'hDEAD_BEEF, data returned on timeout

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
c0_req  in  1  core0 read request pulse
c0_addr  in  ADDR_W  core0 address, sampled with c0_req
c0_busy  out  1  core0 request pending
c0_rvalid  out  1  core0 response strobe, one cycle
c0_rdata  out  DATA_W  core0 read data
c0_err  out  1  core0 error, qualified by c0_rvalid
c0_overrun  out  1  sticky: core0 issued a request while busy
c1_req, c1_addr, c1_busy, c1_rvalid, c1_rdata, c1_err, c1_overrun: same as the core0 ports, for core1
m_arvalid  out  1  read address valid
m_araddr  out  ADDR_W  read address
m_arready  in  1  read address accepted
m_rvalid  in  1  read data valid (rready is implicitly always 1)
m_rdata  in  DATA_W  read data
m_rresp  in  2  read response; nonzero means error

Behaviour:
- Reset (rst synchronous, active-high; clock clk): state=IDLE, both pending=0, last_grant=1 (core0 wins the first tie), timeout counter=0.
  - Output reset values: m_arvalid=0, m_araddr=0, cX_rvalid=0, cX_err=0, cX_rdata=0, cX_overrun=0.
- Capture: cX_req with pendingX=0 latches cX_addr and sets pendingX at that edge. cX_busy = pendingX.
  - cX_req while pendingX=1 is ignored and sets cX_overrun, which stays set until rst.
- FSM IDLE:
  - If any pending is set, grant and go to ADDR.
  - Both pending: grant the core != last_grant. One pending: grant that core.
  - Register owner, m_araddr <= owner's latched address, m_arvalid <= 1.
- FSM ADDR:
  - Hold m_arvalid and m_araddr stable until m_arready.
  - On m_arvalid & m_arready: m_arvalid <= 0, counter <= 0, go to DATA.
  - m_rvalid seen in ADDR is discarded.
- FSM DATA:
  - On m_rvalid: owner's cX_rdata <= m_rdata, cX_err <= (m_rresp != 0), cX_rvalid <= 1 for one cycle, pending_owner <= 0, last_grant <= owner, go to IDLE.
  - Else counter increments. If TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES-1 without m_rvalid: same completion, but with cX_rdata <= TIMEOUT_DATA and cX_err <= 1.
- Latency: req sampled at cycle 0 -> pending set in cycle 1 -> m_arvalid high in cycle 2.
  - m_rvalid sampled at cycle n -> cX_rvalid high and cX_busy low in cycle n+1.
  - The other core may be granted in that same cycle n+1 (IDLE->ADDR at the end of n+1).
- cX_rdata holds its last value between responses. cX_rvalid is never asserted to both cores in one cycle.
- Same-core req in the cycle its pending clears (cX_rvalid cycle) is accepted, because busy is already low.
- m_rvalid arriving in IDLE (a late response after timeout or reset) is discarded without effect.
- Reset mid-transaction aborts everything: no response is delivered for the aborted request.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. It saturates and does not wrap.

Test Plan:
1. Single core0 read: c0_req at cycle 0 with addr 0x4000_0010; slave gives arready at once and rvalid 2 cycles later with 0x1234_5678, rresp 0 -> arvalid in cycle 2; c0_rvalid=1 for one cycle with c0_rdata=0x1234_5678 and c0_err=0; c1 outputs unchanged.
2. Simultaneous c0_req and c1_req, out of reset -> core0 is served first, then core1. Repeat with both requesting continuously for 6 transactions -> grant order 0,1,0,1,0,1.
3. Backpressure: arready withheld for 5 cycles -> m_arvalid and m_araddr stay stable; no response until the handshake completes; busy stays high throughout.
4. Error and timeout: rresp=2'b10 -> cX_err=1 with slave data. With TIMEOUT_CYCLES=8 and no rvalid -> response exactly 8 cycles after entering DATA, rdata=0xDEAD_BEEF, err=1. A late rvalid afterwards is ignored.
5. Overrun: a second c1_req while c1_busy=1 -> c1_overrun=1; the original request completes normally; only one AR is issued.
6. rst asserted in DATA -> all outputs return to reset values next cycle. A later m_rvalid produces no cX_rvalid. A new request then completes normally.

Source files
------------

// File: rtl/io_read_arbiter.sv
// io_read_arbiter
//   Shares one AXI-lite-style read channel between the IO load/store sub-units of two cores.
//   Each core posts a one-cycle read request; requests are latched, granted round-robin, and
//   serviced one at a time (AR handshake, then R). A per-transaction timeout forces an error
//   response if the slave never answers.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cX_req / cX_addr         core X request pulse and address (X = 0, 1)
//   cX_busy                  core X has a request pending
//   cX_rvalid/rdata/err      core X one-cycle response strobe, data, error flag
//   cX_overrun               sticky: core X requested while busy
//   m_ar*                    read address channel to the slave
//   m_rvalid/rdata/rresp     read data channel from the slave (rready is always 1)
module io_read_arbiter #(
   parameter int unsigned       ADDR_W         = 32,
   parameter int unsigned       DATA_W         = 32,
   parameter int unsigned       TIMEOUT_CYCLES = 256,
   parameter logic [DATA_W-1:0] TIMEOUT_DATA   = DATA_W'(32'hDEAD_BEEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c0_req,
   input  logic [ADDR_W-1:0] c0_addr,
   output logic              c0_busy,
   output logic              c0_rvalid,
   output logic [DATA_W-1:0] c0_rdata,
   output logic              c0_err,
   output logic              c0_overrun,
   input  logic              c1_req,
   input  logic [ADDR_W-1:0] c1_addr,
   output logic              c1_busy,
   output logic              c1_rvalid,
   output logic [DATA_W-1:0] c1_rdata,
   output logic              c1_err,
   output logic              c1_overrun,
   output logic              m_arvalid,
   output logic [ADDR_W-1:0] m_araddr,
   input  logic              m_arready,
   input  logic              m_rvalid,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_rresp
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              arvalid_q, arvalid_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;

   logic [1:0]        pending_q, pending_d;
   logic [ADDR_W-1:0] addr_q [2];
   logic [ADDR_W-1:0] addr_d [2];
   logic [1:0]        rvalid_q, rvalid_d;
   logic [1:0]        err_q, err_d;
   logic [1:0]        overrun_q, overrun_d;
   logic [DATA_W-1:0] rdata_q [2];
   logic [DATA_W-1:0] rdata_d [2];

   logic [1:0]        req;
   logic [ADDR_W-1:0] req_addr [2];

   // Completion of the current transaction (slave response or timeout)
   logic              done;
   logic [DATA_W-1:0] done_data;
   logic              done_err;
   logic              grant_core;

   assign req         = {c1_req, c0_req};
   assign req_addr[0] = c0_addr;
   assign req_addr[1] = c1_addr;

   // Transaction FSM
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      arvalid_d    = arvalid_q;
      araddr_d     = araddr_q;
      done         = 1'b0;
      done_data    = m_rdata;
      done_err     = 1'b0;
      grant_core   = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A late m_rvalid here is ignored
            if (|pending_q) begin
               // Both pending: alternate away from the last served core
               grant_core = (pending_q == 2'b11) ? ~last_grant_q : pending_q[1];
               owner_d    = grant_core;
               araddr_d   = addr_q[grant_core];
               arvalid_d  = 1'b1;
               state_d    = StAddr;
            end
         end
         StAddr: begin
            // m_arvalid is high throughout this state; m_rvalid is ignored
            if (m_arready) begin
               arvalid_d = 1'b0;
               cnt_d     = '0;
               state_d   = StData;
            end
         end
         StData: begin
            if (m_rvalid) begin
               done      = 1'b1;
               done_data = m_rdata;
               done_err  = |m_rresp;
            end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
               done      = 1'b1;
               done_data = TIMEOUT_DATA;
               done_err  = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (done) begin
               last_grant_d = owner_q;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Per-core request capture and response delivery
   always_comb begin
      pending_d = pending_q;
      overrun_d = overrun_q;
      rvalid_d  = '0;
      err_d     = err_q;
      rdata_d   = rdata_q;
      addr_d    = addr_q;

      for (int i = 0; i < 2; i++) begin
         if (req[i]) begin
            if (pending_q[i]) begin
               overrun_d[i] = 1'b1;
            end else begin
               pending_d[i] = 1'b1;
               addr_d[i]    = req_addr[i];
            end
         end
      end

      // Owner is always pending here, so a same-edge request from it is an overrun
      if (done) begin
         pending_d[owner_q] = 1'b0;
         rvalid_d[owner_q]  = 1'b1;
         rdata_d[owner_q]   = done_data;
         err_d[owner_q]     = done_err;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         arvalid_q    <= 1'b0;
         araddr_q     <= '0;
         pending_q    <= '0;
         rvalid_q     <= '0;
         err_q        <= '0;
         overrun_q    <= '0;
         for (int i = 0; i < 2; i++) begin
            addr_q[i]  <= '0;
            rdata_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         arvalid_q    <= arvalid_d;
         araddr_q     <= araddr_d;
         pending_q    <= pending_d;
         rvalid_q     <= rvalid_d;
         err_q        <= err_d;
         overrun_q    <= overrun_d;
         for (int i = 0; i < 2; i++) begin
            addr_q[i]  <= addr_d[i];
            rdata_q[i] <= rdata_d[i];
         end
      end
   end

   assign m_arvalid  = arvalid_q;
   assign m_araddr   = araddr_q;

   assign c0_busy    = pending_q[0];
   assign c0_rvalid  = rvalid_q[0];
   assign c0_rdata   = rdata_q[0];
   assign c0_err     = err_q[0];
   assign c0_overrun = overrun_q[0];

   assign c1_busy    = pending_q[1];
   assign c1_rvalid  = rvalid_q[1];
   assign c1_rdata   = rdata_q[1];
   assign c1_err     = err_q[1];
   assign c1_overrun = overrun_q[1];

endmodule
